// File: rtl/lsu_uart_bridge.sv
// Load/store unit that tunnels CPU memory accesses over a byte-wide UART link.
// Each access sends a flag byte and the address MSB first, then sends store data or collects load data.
module lsu_uart_bridge #(
  parameter int         DATA_BYTES = 2,
  parameter int         ADDR_BYTES = 1,
  parameter int         TIMEOUT    = 65535,
  parameter logic [7:0] FLAG_LOAD  = 8'h01,
  parameter logic [7:0] FLAG_STORE = 8'h02,
  localparam int        DW         = 8 * DATA_BYTES,
  localparam int        AW         = 8 * ADDR_BYTES
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic          rsp_err,
  output logic [DW-1:0] rsp_rdata,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  input  logic          tx_done,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          busy
);

  localparam int MAXB = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int CW   = $clog2(MAXB) + 1;
  localparam int TW   = $clog2(TIMEOUT + 2);
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLAG,
    S_ADDR,
    S_WDATA,
    S_RDATA,
    S_DONE
  } state_t;

  state_t        state_q;
  logic          is_load_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rx_shift_q;
  logic [DW-1:0] rsp_rdata_q;
  logic [CW-1:0] cnt_q;
  logic [TW-1:0] timer_q;
  logic          tx_start_q;
  logic [7:0]    tx_data_q;
  logic          rsp_valid_q;
  logic          rsp_err_q;

  logic          tx_ack_d;
  logic          time_up_d;
  logic          last_addr_d;
  logic          last_data_d;
  logic [DW-1:0] rx_word_d;

  // tx_done in the same cycle as the start pulse belongs to the previous byte, so it is ignored
  assign tx_ack_d    = tx_done && !tx_start_q;
  assign time_up_d   = (TIMEOUT != 0) && (timer_q >= TW'(TIMEOUT - 1));
  assign last_addr_d = (cnt_q == CW'(ADDR_BYTES - 1));
  assign last_data_d = (cnt_q == CW'(DATA_BYTES - 1));
  assign rx_word_d   = (rx_shift_q << 8) | DW'(rx_data);

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;

  // Timer reads 0 in a tx_start cycle and 1 the cycle after a tx_done/rx_valid, so every
  // wait times out exactly TIMEOUT cycles after the event that began it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      is_load_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rx_shift_q  <= '0;
      rsp_rdata_q <= '0;
      cnt_q       <= '0;
      timer_q     <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      tx_start_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      timer_q     <= timer_q + TW'(1);
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            is_load_q <= (req_op == OP_LOAD);
            cnt_q     <= '0;
            timer_q   <= '0;
            if (req_op == OP_LOAD || req_op == OP_STORE) begin
              state_q    <= S_FLAG;
              tx_start_q <= 1'b1;
              tx_data_q  <= (req_op == OP_LOAD) ? FLAG_LOAD : FLAG_STORE;
            end else begin
              state_q     <= S_DONE;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end
          end
        end
        S_FLAG: begin
          if (tx_ack_d) begin
            state_q    <= S_ADDR;
            cnt_q      <= '0;
            tx_start_q <= 1'b1;
            tx_data_q  <= addr_q[AW-1 -: 8];
            addr_q     <= addr_q << 8;
            timer_q    <= '0;
          end else if (time_up_d) begin
            state_q     <= S_DONE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
          end
        end
        S_ADDR: begin
          if (tx_ack_d) begin
            if (last_addr_d) begin
              cnt_q <= '0;
              if (is_load_q) begin
                state_q <= S_RDATA;
                timer_q <= TW'(1);
              end else begin
                state_q    <= S_WDATA;
                tx_start_q <= 1'b1;
                tx_data_q  <= wdata_q[DW-1 -: 8];
                wdata_q    <= wdata_q << 8;
                timer_q    <= '0;
              end
            end else begin
              cnt_q      <= cnt_q + CW'(1);
              tx_start_q <= 1'b1;
              tx_data_q  <= addr_q[AW-1 -: 8];
              addr_q     <= addr_q << 8;
              timer_q    <= '0;
            end
          end else if (time_up_d) begin
            state_q     <= S_DONE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
          end
        end
        S_WDATA: begin
          if (tx_ack_d) begin
            if (last_data_d) begin
              state_q     <= S_DONE;
              cnt_q       <= '0;
              rsp_valid_q <= 1'b1;
            end else begin
              cnt_q      <= cnt_q + CW'(1);
              tx_start_q <= 1'b1;
              tx_data_q  <= wdata_q[DW-1 -: 8];
              wdata_q    <= wdata_q << 8;
              timer_q    <= '0;
            end
          end else if (time_up_d) begin
            state_q     <= S_DONE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
          end
        end
        S_RDATA: begin
          // rsp_rdata only changes on a completed load, so timeouts keep the old word
          if (rx_valid) begin
            rx_shift_q <= rx_word_d;
            timer_q    <= TW'(1);
            if (last_data_d) begin
              state_q     <= S_DONE;
              cnt_q       <= '0;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rx_word_d;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end else if (time_up_d) begin
            state_q     <= S_DONE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_uart_bridge.sv
// Bench for lsu_uart_bridge: a default-parameter instance (A) and a 4-byte data, 2-byte address,
// TIMEOUT=16 instance (B). Both are driven by a cycle-level UART responder and checked against a byte-sequence model.
module tb_lsu_uart_bridge;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        reqValidA, reqValidB;
  logic [1:0]  reqOp;
  logic [15:0] reqAddr;
  logic [31:0] reqWdata;
  logic [7:0]  rxData;
  logic        txDoneA, rxValidA, txDoneB, rxValidB;

  logic        reqReadyA, rspValidA, rspErrA, txStartA, busyA;
  logic [15:0] rspRdataA;
  logic [7:0]  txDataA;
  logic        reqReadyB, rspValidB, rspErrB, txStartB, busyB;
  logic [31:0] rspRdataB;
  logic [7:0]  txDataB;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] modelRdata [2];

  logic [63:0] txSeq;
  int          txCount, rspCycle, lastEvt, firstStart;
  bit          gotRsp, busyBad, stableBad, acceptReady, readyAfter, rspAfter;
  logic        rspErrSeen;
  logic [31:0] rspRdataSeen;

  lsu_uart_bridge dutA (
    .clk(clock), .reset(reset),
    .req_valid(reqValidA), .req_ready(reqReadyA), .req_op(reqOp),
    .req_addr(reqAddr[7:0]), .req_wdata(reqWdata[15:0]),
    .rsp_valid(rspValidA), .rsp_err(rspErrA), .rsp_rdata(rspRdataA),
    .tx_start(txStartA), .tx_data(txDataA), .tx_done(txDoneA),
    .rx_valid(rxValidA), .rx_data(rxData), .busy(busyA)
  );

  lsu_uart_bridge #(.DATA_BYTES(4), .ADDR_BYTES(2), .TIMEOUT(16)) dutB (
    .clk(clock), .reset(reset),
    .req_valid(reqValidB), .req_ready(reqReadyB), .req_op(reqOp),
    .req_addr(reqAddr), .req_wdata(reqWdata),
    .rsp_valid(rspValidB), .rsp_err(rspErrB), .rsp_rdata(rspRdataB),
    .tx_start(txStartB), .tx_data(txDataB), .tx_done(txDoneB),
    .rx_valid(rxValidB), .rx_data(rxData), .busy(busyB)
  );

  // Expected UART byte stream: flag, address MSB first, then store data MSB first
  function automatic logic [63:0] expSeqOf(input int sel, input logic [1:0] op,
                                           input logic [15:0] addr, input logic [31:0] wdata);
    logic [63:0] s;
    int ab, db;
    ab = (sel == 0) ? 1 : 2;
    db = (sel == 0) ? 2 : 4;
    s = '0;
    if (op == 2'b01 || op == 2'b10) begin
      s = {56'h0, (op == 2'b01) ? 8'h01 : 8'h02};
      for (int i = ab - 1; i >= 0; i--) s = {s[55:0], addr[8*i +: 8]};
      if (op == 2'b10) for (int i = db - 1; i >= 0; i--) s = {s[55:0], wdata[8*i +: 8]};
    end
    return s;
  endfunction

  function automatic int expCountOf(input int sel, input logic [1:0] op);
    int ab, db;
    ab = (sel == 0) ? 1 : 2;
    db = (sel == 0) ? 2 : 4;
    if (op == 2'b01) return 1 + ab;
    if (op == 2'b10) return 1 + ab + db;
    return 0;
  endfunction

  // Runs one access cycle by cycle, acting as the UART; it only records observations
  task automatic applyStimulus(input int sel, input logic [1:0] op, input logic [15:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rxWord,
                               input int txDelay, input int rxGap, input bit rxEnable,
                               input bit noise, input bit chain, input int stopAfterTx);
    int ab, db, cd, txAcks, rxSent, gap;
    bit rxPhase, st, rv, rdy, bsy, dDrv, rDrv;
    logic [7:0] td, curByte;
    ab = (sel == 0) ? 1 : 2;
    db = (sel == 0) ? 2 : 4;
    cd = 0; txAcks = 0; rxSent = 0; gap = rxGap; rxPhase = 0; curByte = '0;
    txSeq = '0; txCount = 0; gotRsp = 0; rspCycle = -1; lastEvt = 0; firstStart = -1;
    busyBad = 0; stableBad = 0; rspErrSeen = 1'b0; rspRdataSeen = '0;
    readyAfter = 0; rspAfter = 1;
    if (!chain) @(negedge clock);
    acceptReady = (sel == 0) ? reqReadyA : reqReadyB;
    reqOp = op; reqAddr = addr; reqWdata = wdata;
    if (sel == 0) reqValidA = 1'b1; else reqValidB = 1'b1;
    for (int c = 1; c < 3000; c++) begin
      @(negedge clock);
      reqValidA = 1'b0; reqValidB = 1'b0;
      reqOp = 2'($urandom); reqAddr = 16'($urandom); reqWdata = $urandom; rxData = 8'($urandom);
      dDrv = 0; rDrv = 0;
      st  = (sel == 0) ? txStartA  : txStartB;
      td  = (sel == 0) ? txDataA   : txDataB;
      rv  = (sel == 0) ? rspValidA : rspValidB;
      rdy = (sel == 0) ? reqReadyA : reqReadyB;
      bsy = (sel == 0) ? busyA     : busyB;
      if (!bsy || rdy) busyBad = 1;
      if (rv) begin
        gotRsp = 1; rspCycle = c;
        rspErrSeen   = (sel == 0) ? rspErrA : rspErrB;
        rspRdataSeen = (sel == 0) ? {16'h0, rspRdataA} : rspRdataB;
      end else begin
        if (st) begin
          txSeq = {txSeq[55:0], td}; txCount++; curByte = td; cd = txDelay;
          if (firstStart < 0) firstStart = c;
          if (noise) dDrv = 1;
        end else if (cd > 0) begin
          if (td !== curByte) stableBad = 1;
          cd--;
          if (cd == 0) begin dDrv = 1; txAcks++; lastEvt = c; end
        end
        if (rxPhase) begin
          if (rxEnable && rxSent < db) begin
            if (gap == 0) begin
              rDrv = 1; rxData = rxWord[8*(db-1-rxSent) +: 8]; rxSent++; lastEvt = c; gap = rxGap;
            end else gap--;
          end
          if (noise && $urandom_range(0, 2) == 0) dDrv = 1;
        end else if (noise && $urandom_range(0, 3) == 0) rDrv = 1;
        if (op == 2'b01 && txAcks == 1 + ab) rxPhase = 1;
      end
      if (sel == 0) begin txDoneA = dDrv; rxValidA = rDrv; end
      else begin txDoneB = dDrv; rxValidB = rDrv; end
      if (gotRsp || (stopAfterTx > 0 && txCount == stopAfterTx)) break;
    end
    if (stopAfterTx == 0) begin
      @(negedge clock);
      txDoneA = 1'b0; rxValidA = 1'b0; txDoneB = 1'b0; rxValidB = 1'b0;
      readyAfter = (sel == 0) ? reqReadyA : reqReadyB;
      rspAfter   = (sel == 0) ? rspValidA : rspValidB;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    vectors++;
    if ({reqReadyA, busyA, rspValidA, rspErrA, txStartA} !== 5'b10000) begin
      miscompares++; $display("[TB] FAIL reset_ctrl_A: got %b expected 10000", {reqReadyA, busyA, rspValidA, rspErrA, txStartA});
    end
    vectors++;
    if (rspRdataA !== 16'h0 || txDataA !== 8'h0) begin
      miscompares++; $display("[TB] FAIL reset_data_A: got rdata=%h tx=%h expected 0/0", rspRdataA, txDataA);
    end
    vectors++;
    if ({reqReadyB, busyB, rspValidB, rspErrB, txStartB} !== 5'b10000) begin
      miscompares++; $display("[TB] FAIL reset_ctrl_B: got %b expected 10000", {reqReadyB, busyB, rspValidB, rspErrB, txStartB});
    end
    vectors++;
    if (rspRdataB !== 32'h0 || txDataB !== 8'h0) begin
      miscompares++; $display("[TB] FAIL reset_data_B: got rdata=%h tx=%h expected 0/0", rspRdataB, txDataB);
    end
    modelRdata[0] = '0; modelRdata[1] = '0;
  endtask

  task automatic test_load_default();
    applyStimulus(0, 2'b01, 16'h003C, 32'h0, 32'h0000ABCD, 2, 1, 1, 0, 0, 0);
    modelRdata[0] = 32'h0000ABCD;
    vectors++;
    if (txCount != 2 || txSeq !== 64'h013C) begin
      miscompares++; $display("[TB] FAIL load_tx: got %0d bytes %h expected 2 bytes 013c", txCount, txSeq);
    end
    vectors++;
    if (!gotRsp || rspCycle != lastEvt + 1 || rspErrSeen !== 1'b0) begin
      miscompares++; $display("[TB] FAIL load_rsp: got cycle %0d err %b expected cycle %0d err 0", rspCycle, rspErrSeen, lastEvt + 1);
    end
    vectors++;
    if (rspRdataSeen !== 32'h0000ABCD) begin
      miscompares++; $display("[TB] FAIL load_rdata: got %h expected abcd", rspRdataSeen);
    end
    vectors++;
    if (firstStart != 1 || busyBad || stableBad || !acceptReady || !readyAfter || rspAfter) begin
      miscompares++; $display("[TB] FAIL load_handshake: got first=%0d busyBad=%0d stableBad=%0d acc=%0d rdy=%0d rsp=%0d expected 1 0 0 1 1 0",
                              firstStart, busyBad, stableBad, acceptReady, readyAfter, rspAfter);
    end
  endtask

  task automatic test_store_default();
    applyStimulus(0, 2'b10, 16'h0010, 32'h00001234, 32'h0, 5, 0, 1, 0, 0, 0);
    vectors++;
    if (txCount != 4 || txSeq !== 64'h02101234) begin
      miscompares++; $display("[TB] FAIL store_tx: got %0d bytes %h expected 4 bytes 02101234", txCount, txSeq);
    end
    vectors++;
    if (!gotRsp || rspCycle != 25 || rspErrSeen !== 1'b0) begin
      miscompares++; $display("[TB] FAIL store_rsp: got cycle %0d err %b expected cycle 25 err 0", rspCycle, rspErrSeen);
    end
    vectors++;
    if (rspRdataSeen !== modelRdata[0] || busyBad || stableBad || !readyAfter || rspAfter) begin
      miscompares++; $display("[TB] FAIL store_hold: got rdata %h busyBad=%0d stableBad=%0d rdy=%0d rsp=%0d expected %h 0 0 1 0",
                              rspRdataSeen, busyBad, stableBad, readyAfter, rspAfter, modelRdata[0]);
    end
  endtask

  task automatic test_invalid_op();
    logic [1:0] ops [2];
    ops[0] = 2'b11; ops[1] = 2'b00;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, ops[i], 16'h0055, 32'h0000BEEF, 32'h0, 2, 0, 1, 0, 0, 0);
      vectors++;
      if (txCount != 0 || !gotRsp || rspCycle != 1 || rspErrSeen !== 1'b1) begin
        miscompares++; $display("[TB] FAIL invalid_op_%0d: got tx %0d cycle %0d err %b expected tx 0 cycle 1 err 1", ops[i], txCount, rspCycle, rspErrSeen);
      end
      vectors++;
      if (rspRdataSeen !== modelRdata[0] || !readyAfter || rspAfter) begin
        miscompares++; $display("[TB] FAIL invalid_hold_%0d: got rdata %h rdy %0d rsp %0d expected %h 1 0", ops[i], rspRdataSeen, readyAfter, rspAfter, modelRdata[0]);
      end
    end
  endtask

  task automatic test_wide_load();
    applyStimulus(1, 2'b01, 16'hBEEF, 32'h0, 32'h11223344, 1, 0, 1, 0, 0, 0);
    modelRdata[1] = 32'h11223344;
    vectors++;
    if (txCount != 3 || txSeq !== 64'h01BEEF) begin
      miscompares++; $display("[TB] FAIL wide_tx: got %0d bytes %h expected 3 bytes 01beef", txCount, txSeq);
    end
    vectors++;
    if (!gotRsp || rspCycle != 11 || rspErrSeen !== 1'b0 || rspRdataSeen !== 32'h11223344) begin
      miscompares++; $display("[TB] FAIL wide_rsp: got cycle %0d err %b rdata %h expected 11 0 11223344", rspCycle, rspErrSeen, rspRdataSeen);
    end
  endtask

  task automatic test_timeout();
    applyStimulus(1, 2'b01, 16'h1234, 32'h0, 32'h0, 1, 0, 0, 0, 0, 0);
    vectors++;
    if (!gotRsp || rspCycle != lastEvt + 16 || rspErrSeen !== 1'b1) begin
      miscompares++; $display("[TB] FAIL timeout_rx: got cycle %0d err %b expected cycle %0d err 1", rspCycle, rspErrSeen, lastEvt + 16);
    end
    vectors++;
    if (rspRdataSeen !== modelRdata[1] || !readyAfter) begin
      miscompares++; $display("[TB] FAIL timeout_rx_hold: got rdata %h rdy %0d expected %h 1", rspRdataSeen, readyAfter, modelRdata[1]);
    end
    applyStimulus(1, 2'b10, 16'h0F0F, 32'hCAFEF00D, 32'h0, 0, 0, 1, 0, 0, 0);
    vectors++;
    if (txCount != 1 || txSeq !== 64'h02 || !gotRsp || rspCycle != 17 || rspErrSeen !== 1'b1) begin
      miscompares++; $display("[TB] FAIL timeout_tx: got tx %0d seq %h cycle %0d err %b expected 1 02 17 1", txCount, txSeq, rspCycle, rspErrSeen);
    end
  endtask

  task automatic test_random(input int sel, input int n, input bit chain);
    logic [1:0] op;
    logic [15:0] addr;
    logic [31:0] wdata, rxWord, mask;
    int r, expRsp;
    bit valid;
    mask = (sel == 0) ? 32'h0000FFFF : 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      op = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b00 : 2'b11;
      addr = 16'($urandom); wdata = $urandom; rxWord = $urandom;
      applyStimulus(sel, op, addr, wdata, rxWord, $urandom_range(1, 6), $urandom_range(0, 4), 1, 1, chain && i > 0, 0);
      valid = (op == 2'b01 || op == 2'b10);
      expRsp = valid ? lastEvt + 1 : 1;
      if (op == 2'b01) modelRdata[sel] = rxWord & mask;
      vectors++;
      if (txCount != expCountOf(sel, op) || txSeq !== expSeqOf(sel, op, addr, wdata)) begin
        miscompares++; $display("[TB] FAIL rand_tx[%0d.%0d]: got %0d bytes %h expected %0d bytes %h", sel, i, txCount, txSeq,
                                expCountOf(sel, op), expSeqOf(sel, op, addr, wdata));
      end
      vectors++;
      if (!gotRsp || rspCycle != expRsp || rspErrSeen !== !valid) begin
        miscompares++; $display("[TB] FAIL rand_rsp[%0d.%0d]: got cycle %0d err %b expected cycle %0d err %b", sel, i, rspCycle, rspErrSeen, expRsp, !valid);
      end
      vectors++;
      if (rspRdataSeen !== modelRdata[sel]) begin
        miscompares++; $display("[TB] FAIL rand_rdata[%0d.%0d]: got %h expected %h", sel, i, rspRdataSeen, modelRdata[sel]);
      end
      vectors++;
      if (busyBad || stableBad || !acceptReady || !readyAfter || rspAfter || (valid && firstStart != 1)) begin
        miscompares++; $display("[TB] FAIL rand_proto[%0d.%0d]: got busyBad=%0d stableBad=%0d acc=%0d rdy=%0d rsp=%0d first=%0d expected 0 0 1 1 0 1",
                                sel, i, busyBad, stableBad, acceptReady, readyAfter, rspAfter, firstStart);
      end
    end
  endtask

  task automatic test_reset_midaccess();
    bit bad;
    applyStimulus(0, 2'b10, 16'h0010, 32'h00001234, 32'h0, 3, 0, 1, 0, 0, 3);
    reset = 1'b1; txDoneA = 1'b0; rxValidA = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    modelRdata[0] = '0; modelRdata[1] = '0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (txStartA || rspValidA || !reqReadyA || busyA) bad = 1;
      txDoneA = 1'($urandom_range(0, 1));
      rxValidA = 1'($urandom_range(0, 1));
      rxData = 8'($urandom);
    end
    vectors++;
    if (txCount != 3 || bad) begin
      miscompares++; $display("[TB] FAIL reset_abort: got tx before reset %0d, idle violation %0d expected 3, 0", txCount, bad);
    end
    vectors++;
    if (rspRdataA !== 16'h0 || txDataA !== 8'h0) begin
      miscompares++; $display("[TB] FAIL reset_abort_data: got rdata %h tx %h expected 0 0", rspRdataA, txDataA);
    end
    txDoneA = 1'b0; rxValidA = 1'b0;
  endtask

  task automatic checkOutput();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
  endtask

  initial begin
    reset = 1'b1;
    reqValidA = 1'b0; reqValidB = 1'b0; reqOp = 2'b00; reqAddr = '0; reqWdata = '0; rxData = '0;
    txDoneA = 1'b0; rxValidA = 1'b0; txDoneB = 1'b0; rxValidB = 1'b0;
    modelRdata[0] = '0; modelRdata[1] = '0;
    $display("[TB] starting lsu_uart_bridge bench");
    test_reset();
    test_load_default();
    test_store_default();
    test_invalid_op();
    test_wide_load();
    test_timeout();
    test_random(0, 20, 0);
    test_random(1, 20, 0);
    test_random(0, 10, 1);
    test_random(1, 10, 1);
    test_reset_midaccess();
    checkOutput();
    $finish;
  end

endmodule
